// File: rtl/id_eeprom_responder.sv
// id_eeprom_responder: two-wire (I2C-style) EEPROM responder for the ID-EEPROM SCL/SDA pair.
// Holds a 2**ADDR_W byte array. The local side can preload it. The bus supports random write,
// random read and sequential read.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   scl_in, sda_in        bus clock / data as seen on the pins (asynchronous to clk)
//   sda_oe                1 = pull SDA low (open drain), 0 = release
//   cfg_we/addr/wdata     local preload write port (same-cycle write)
//   wp                    write protect (only when ID_EEPROM_WP_EN is defined)
//   busy                  addressed transaction in progress
//   wr_done               one-cycle pulse per bus-written byte committed to the array
//
// Optional feature macro: ID_EEPROM_WP_EN adds the wp input. Protected data bytes are
// not stored and are NACKed.
module id_eeprom_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_wdata,
`ifdef ID_EEPROM_WP_EN
  input  logic              wp,
`endif
  output logic              busy,
  output logic              wr_done
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StAckDev, StWordAddr, StAckWord,
    StWriteData, StAckData, StReadData, StReadAck, StIgnore
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        scl_sync_q, sda_sync_q;  // [1:0] synchroniser, [2] previous sample
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        sh_q, sh_d;              // 7 bits suffice: the 8th arrives with the edge
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              ack_on_q, ack_on_d;      // ack slot: 0 = before drive, 1 = driving
  logic              nack_q, nack_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              wr_done_q, wr_done_d;
  logic              bus_we;
  logic [7:0]        mem_q [Depth];

  logic scl_rise, scl_fall, scl_high, start_det, stop_det, sda_bit, wp_int;
  logic [7:0] shifted, mem_rd;

`ifdef ID_EEPROM_WP_EN
  assign wp_int = wp;
`else
  assign wp_int = 1'b0;
`endif

  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign scl_high  = scl_sync_q[1] & scl_sync_q[2];
  assign start_det = scl_high & ~sda_sync_q[1] & sda_sync_q[2];
  assign stop_det  = scl_high & sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_bit   = sda_sync_q[1];
  assign shifted   = {sh_q, sda_bit};
  assign mem_rd    = mem_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_on_d  = ack_on_q;
    nack_d    = nack_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_done_d = 1'b0;
    bus_we    = 1'b0;
    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = StDevAddr;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        StDevAddr, StWordAddr, StWriteData: begin
          if (scl_rise) begin
            sh_d      = shifted[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              ack_on_d  = 1'b0;
              nack_d    = 1'b0;
              if (state_q == StDevAddr) begin
                if (shifted[7:1] == DEV_ADDR) begin
                  state_d = StAckDev;
                  rw_d    = shifted[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = StIgnore;
                  busy_d  = 1'b0;
                end
              end else if (state_q == StWordAddr) begin
                ptr_d   = shifted[ADDR_W-1:0];
                state_d = StAckWord;
              end else begin
                // Pointer advances even when the byte is write-protected.
                ptr_d   = ptr_q + 1'b1;
                state_d = StAckData;
                if (wp_int) begin
                  nack_d = 1'b1;
                end else begin
                  bus_we    = 1'b1;
                  wr_done_d = 1'b1;
                end
              end
            end
          end
        end
        StAckDev, StAckWord, StAckData: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d = 1'b1;
              oe_d     = ~nack_q;
            end else begin
              ack_on_d  = 1'b0;
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAckDev && rw_q) begin
                // Read byte is loaded and its MSB driven on the ack-ending fall.
                sh_d    = mem_rd[6:0];
                oe_d    = ~mem_rd[7];
                state_d = StReadData;
              end else if (state_q == StAckDev) begin
                state_d = StWordAddr;
              end else begin
                state_d = StWriteData;
              end
            end
          end
        end
        StReadData: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              ptr_d   = ptr_q + 1'b1;
              state_d = StReadAck;
            end else begin
              oe_d = ~sh_q[6];
              sh_d = {sh_q[5:0], 1'b0};
            end
          end
        end
        StReadAck: begin
          // Only a master ACK keeps us here until the next fall.
          if (scl_rise && sda_bit) begin
            state_d = StIgnore;
          end else if (scl_fall) begin
            sh_d      = mem_rd[6:0];
            oe_d      = ~mem_rd[7];
            bit_cnt_d = '0;
            state_d   = StReadData;
          end
        end
        StIdle, StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_on_q   <= 1'b0;
      nack_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_in};
      sda_sync_q <= {sda_sync_q[1:0], sda_in};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_on_q   <= ack_on_d;
      nack_q     <= nack_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_done_q  <= wr_done_d;
    end
  end

  // Array is not reset. The bus write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (cfg_we) mem_q[cfg_addr] <= cfg_wdata;
    if (bus_we) mem_q[ptr_q] <= shifted;
  end

  // Reset releases SDA immediately rather than waiting for the register.
  assign sda_oe  = oe_q & ~reset;
  assign busy    = busy_q;
  assign wr_done = wr_done_q;

endmodule

// File: tb/tb_id_eeprom_responder.sv
// Directed bench for id_eeprom_responder: bit-banged master with open-drain SDA model.
module tb_id_eeprom_responder;

  localparam int H = 10;  // clk cycles per SCL phase

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
`ifdef ID_EEPROM_WP_EN
  logic       wp = 1'b0;
`endif
  logic       sda_pin, sda_oe, busy, wr_done;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  assign sda_pin = sda_m & ~sda_oe;

  id_eeprom_responder #(.DEV_ADDR(7'h50), .ADDR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m),
    .sda_in   (sda_pin),
    .sda_oe   (sda_oe),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
`ifdef ID_EEPROM_WP_EN
    .wp       (wp),
`endif
    .busy     (busy),
    .wr_done  (wr_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_done) wr_cnt <= wr_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_addr = a;
    cfg_wdata = d;
    cfg_we = 1'b1;
    wait_clk(1);
    cfg_we = 1'b0;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(H);
    s = sda_pin;
    scl_m = 1'b0;
    wait_clk(2);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(mack, s);
  endtask

  initial begin
    logic       a;
    logic [7:0] b;
    logic [7:0] wr_bytes [5];
    logic [7:0] rd_exp [4];
    int snap_wr, snap_oe, snap_busy;
    wr_bytes = '{8'hA0, 8'h0E, 8'h11, 8'h22, 8'h33};
    rd_exp   = '{8'h11, 8'h22, 8'h33, 8'h5A};

    wait_clk(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    reset = 1'b0;
    wait_clk(2);
    cfg_write(4'd3, 8'hA5);
    cfg_write(4'd1, 8'h5A);
    cfg_write(4'd0, 8'hC3);
    cfg_write(4'd5, 8'h66);
    cfg_write(4'd6, 8'h6B);

    // Random read of address 3
    bus_start();
    write_byte(8'hA0, a); check("t1_ack_dev", a, 1'b0);
    check("t1_busy_hi", busy, 1'b1);
    write_byte(8'h03, a); check("t1_ack_word", a, 1'b0);
    bus_start();
    write_byte(8'hA1, a); check("t1_ack_rd", a, 1'b0);
    read_byte(1'b1, b); check("t1_rdata", b, 8'hA5);
    bus_stop();
    check("t1_busy_lo", busy, 1'b0);
    check("t1_oe_lo", sda_oe, 1'b0);

    // Write 3 bytes from 0x0E with pointer wrap
    snap_wr = wr_cnt;
    bus_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(wr_bytes[i], a);
      check($sformatf("t2_wr_ack%0d", i), a, 1'b0);
    end
    bus_stop();
    check("t2_wr_done_cnt", wr_cnt - snap_wr, 3);

    // Sequential read from 14: ACK,ACK,ACK,NACK
    bus_start();
    write_byte(8'hA0, a); check("t4_ack_dev", a, 1'b0);
    write_byte(8'h0E, a); check("t4_ack_word", a, 1'b0);
    bus_start();
    write_byte(8'hA1, a); check("t4_ack_rd", a, 1'b0);
    for (int i = 0; i < 4; i++) begin
      read_byte(i == 3, b);
      check($sformatf("t4_rdata%0d", i), b, rd_exp[i]);
    end
    wait_clk(4);
    check("t4_oe_after_nack", sda_oe, 1'b0);
    bus_stop();

    // Wrong device address
    snap_wr = wr_cnt; snap_oe = oe_cnt; snap_busy = busy_cnt;
    bus_start();
    write_byte(8'hA2, a); check("t3_nack_dev", a, 1'b1);
    write_byte(8'h05, a); check("t3_nack_word", a, 1'b1);
    write_byte(8'h99, a);
    bus_stop();
    check("t3_oe_cycles", oe_cnt - snap_oe, 0);
    check("t3_busy_cycles", busy_cnt - snap_busy, 0);
    check("t3_wr_done_cnt", wr_cnt - snap_wr, 0);
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h05, a);
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b1, b); check("t3_array5", b, 8'h66);
    bus_stop();

    // Reset while driving a 0 data bit (array[14] = 0x11, MSB 0)
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h0E, a);
    bus_start();
    write_byte(8'hA1, a); check("t5_ack_rd", a, 1'b0);
    wait_clk(4);
    check("t5_driving", sda_oe, 1'b1);
    reset = 1'b1;
    wait_clk(1);
    check("t5_oe_in_reset", sda_oe, 1'b0);
    check("t5_busy_in_reset", busy, 1'b0);
    reset = 1'b0;
    wait_clk(2);
    check("t5_oe_after_reset", sda_oe, 1'b0);
    bus_start();
    write_byte(8'hA1, a); check("t5_ack_after_reset", a, 1'b0);
    read_byte(1'b1, b); check("t5_rdata_ptr0", b, 8'h33);
    bus_stop();

`ifdef ID_EEPROM_WP_EN
    // Write-protected data byte
    wp = 1'b1;
    snap_wr = wr_cnt;
    bus_start();
    write_byte(8'hA0, a); check("wp_ack_dev", a, 1'b0);
    write_byte(8'h05, a); check("wp_ack_word", a, 1'b0);
    write_byte(8'h77, a); check("wp_nack_data", a, 1'b1);
    bus_stop();
    check("wp_wr_done_cnt", wr_cnt - snap_wr, 0);
    bus_start();
    write_byte(8'hA1, a); check("wp_ack_rd", a, 1'b0);
    read_byte(1'b1, b); check("wp_ptr6", b, 8'h6B);
    bus_stop();
    wp = 1'b0;
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h05, a);
    bus_start();
    write_byte(8'hA1, a);
    read_byte(1'b1, b); check("wp_array5", b, 8'h66);
    bus_stop();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
